req_enc_16x4: RTL
=================

Name: req_enc_16x4

Overview:
- Sequential 16-to-4 request encoder: the inverse direction of the team's 4x16 one-hot decoder.
- Captures rising edges on 16 request lines into a pending register and presents one pending index at a time as a 4-bit code.
- The code is presented with a valid/ack handshake to a downstream consumer, such as the 4x16 decoder or a service sequencer.
- Supports fixed-priority or round-robin selection, per-line masking, and a sticky overflow flag.

Parameters:
- ROUND_ROBIN, 0, selection mode: 0 = fixed priority with bit 15 highest; 1 = round-robin starting at rr_ptr.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  16  request lines, sampled every cycle; a 0->1 transition posts a request.
- mask  input  16  1 = line excluded from selection; pending bits are still kept.
- ack  input  1  consumer accepts the presented code; ignored when valid=0.
- clr_ovf  input  1  clears the overflow flag.
- code  output  4  index of the presented request.
- valid  output  1  code is meaningful.
- pend  output  16  pending-request register (direct register view).
- overflow  output  1  sticky flag: a request edge arrived on an already-pending line.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets code=0, valid=0, pend=0, overflow=0, req_q=0, rr_ptr=0, state=IDLE.
  - Reset overrides every other input in that cycle.
- Edge detect:
  - req_q registers req every cycle.
  - rise = req & ~req_q.
  - A line held high through reset produces rise in the first cycle after reset.
- Clear vector: clr = one-hot(code) when valid & ack, else 0.
- Pending update: pend_next = (pend & ~clr) | rise.
  - Set wins: a rise on the line being acked in the same cycle leaves that bit pending.
- Overflow:
  - Set when any i has rise[i] & pend[i] & ~clr[i].
  - Cleared by clr_ovf; set wins over clr_ovf in the same cycle.
- Eligible set: elig = pend & ~mask. Selection uses the registered pend only, not same-cycle rise.
- State machine (2 states):
  - IDLE: valid=0. If elig≠0, register code=sel(elig), set valid=1, go to PRESENT; else stay.
  - PRESENT: code and valid are held stable, even if mask or pend for that line changes.
    - Leave only on ack=1: valid drops to 0 at that edge, pend bit cleared, return to IDLE.
- Latency and throughput:
  - Req sampled high at edge k (low at k-1): pend bit set after edge k, valid=1 after edge k+1.
  - Back-to-back grants: one per 2 cycles (one mandatory IDLE cycle after each ack).
- sel, fixed priority (ROUND_ROBIN=0): highest set index of elig.
- sel, round-robin (ROUND_ROBIN=1):
  - First set bit of elig searching upward from rr_ptr, wrapping 15->0.
  - On ack, rr_ptr = code+1 mod 16, so code 15 gives rr_ptr 0.
- Masking all pending lines holds the block in IDLE with valid=0; pend still accumulates.
- Reset while PRESENT: valid drops and pend clears at that edge; the unacked request is discarded.
- ack while valid=0 has no effect on pend, rr_ptr or state.

Test Plan:
- Fixed priority:
  - Stimulus: reset, then req 0x0000 -> 0x8001 at edge 3, ack held 1.
  - Required: pend=0x8001 after edge 3; valid=1, code=15 after edge 4; after edge 5 valid=0, pend=0x0001; after edge 6 code=0, valid=1.
- Hold and mask:
  - Stimulus: pend=0x0010 presented (code=4), ack=0 for 10 cycles, mask=0x0010 asserted mid-way.
  - Required: code=4, valid=1 stable throughout; ack then clears pend to 0x0000.
  - Follow-up: mask=0xFFFF with pend=0x00FF gives valid=0 indefinitely; mask=0 gives code=7 two edges later.
- Overflow:
  - Stimulus: req bit 2 pulses 1,0,1 while bit 2 is pending and not acked.
  - Required: overflow=1 after the second rise.
  - Same-cycle check: clr_ovf and a new overflow event together leave overflow=1; clr_ovf alone clears it.
- Ack-collision:
  - Stimulus: a rise on bit 9 in the same cycle code=9 is acked.
  - Required: pend[9] remains 1, overflow stays 0, code=9 re-presented 2 edges later.
- Round-robin (ROUND_ROBIN=1):
  - Stimulus: req=0x8003 posted together, ack=1 continuously.
  - Required: grants in order 0, 1, 15; after the grant of 15, rr_ptr=0.
  - Follow-up: re-posting bits 1 and 14 gives grant 1, then 14.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 cycle while valid=1, code=6, req=0x0040 held high.
  - Required: valid=0, pend=0, overflow=0 after the reset edge; pend=0x0040 one edge later, valid=1, code=6 the edge after.

Source files
------------

// File: rtl/req_enc_16x4.sv
// Sequential 16-to-4 request encoder: latches request rising edges into a
// pending register and hands one pending index at a time to a valid/ack consumer.
module req_enc_16x4 #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] mask,
    input  logic        ack,
    input  logic        clr_ovf,
    output logic [3:0]  code,
    output logic        valid,
    output logic [15:0] pend,
    output logic        overflow
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t      state_q;
    logic [15:0] req_q;
    logic [3:0]  rr_ptr_q;

    logic [15:0] rise;
    logic [15:0] clr;
    logic [15:0] pend_d;
    logic [15:0] elig;
    logic        ovf_set;
    logic [3:0]  sel_fixed;
    logic [3:0]  sel_rr;
    logic [3:0]  rr_idx;
    logic        rr_found;
    logic [3:0]  sel;

    // A rise on the line being acked keeps it pending and is not an overflow.
    always_comb begin
        rise    = req & ~req_q;
        clr     = (valid && ack) ? (16'd1 << code) : 16'd0;
        pend_d  = (pend & ~clr) | rise;
        ovf_set = |(rise & pend & ~clr);
        elig    = pend & ~mask;
    end

    always_comb begin
        sel_fixed = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (elig[i]) sel_fixed = 4'(i);
        end
    end

    // Round-robin scan starts at rr_ptr_q and wraps naturally in 4 bits.
    always_comb begin
        sel_rr   = 4'd0;
        rr_found = 1'b0;
        rr_idx   = 4'd0;
        for (int k = 0; k < 16; k++) begin
            rr_idx = rr_ptr_q + 4'(k);
            if (!rr_found && elig[rr_idx]) begin
                sel_rr   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    assign sel = ROUND_ROBIN ? sel_rr : sel_fixed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= 16'd0;
            rr_ptr_q <= 4'd0;
            code     <= 4'd0;
            valid    <= 1'b0;
            pend     <= 16'd0;
            overflow <= 1'b0;
        end else begin
            req_q    <= req;
            pend     <= pend_d;
            overflow <= ovf_set | (overflow & ~clr_ovf);
            case (state_q)
                IDLE: begin
                    if (|elig) begin
                        code    <= sel;
                        valid   <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        valid    <= 1'b0;
                        rr_ptr_q <= code + 4'd1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    valid   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
